// File: rtl/alu_operand_stage.sv
// Operand-fetch stage in front of the ALU: register file, pending-write scoreboard,
// writeback bypass, RAW/WAW stall and a valid/ready output register.
module alu_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 16,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [7:0]                instr_alu_op,
    input  logic [REG_ADDR_WIDTH-1:0] instr_rs0,
    input  logic [REG_ADDR_WIDTH-1:0] instr_rs1,
    input  logic [DATA_WIDTH-1:0]     instr_imm,
    input  logic                      instr_use_imm,
    input  logic [REG_ADDR_WIDTH-1:0] instr_rd,
    input  logic                      instr_wr_en,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      alu_valid,
    input  logic                      alu_ready,
    output logic [7:0]                alu_ctrl,
    output logic [DATA_WIDTH-1:0]     alu_in0,
    output logic [DATA_WIDTH-1:0]     alu_in1,
    output logic [REG_ADDR_WIDTH-1:0] alu_rd,
    output logic                      alu_wr_en
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
    // instr_ready never looks at instr_valid; alu_valid holds, with all alu_* stable,
    // until alu_ready is seen.

    logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]       pending_q, pending_d;

    logic                      alu_valid_q, alu_valid_d;
    logic [7:0]                alu_ctrl_q, alu_ctrl_d;
    logic [DATA_WIDTH-1:0]     alu_in0_q, alu_in0_d;
    logic [DATA_WIDTH-1:0]     alu_in1_q, alu_in1_d;
    logic [REG_ADDR_WIDTH-1:0] alu_rd_q, alu_rd_d;
    logic                      alu_wr_en_q, alu_wr_en_d;

    logic                      wb_hit_rs0, wb_hit_rs1, wb_hit_rd;
    logic                      wb_write;
    logic                      hazard;
    logic                      accept;
    logic [DATA_WIDTH-1:0]     op0, op1;

    assign wb_write   = wb_valid && (wb_addr != '0);
    assign wb_hit_rs0 = wb_valid && (wb_addr == instr_rs0);
    assign wb_hit_rs1 = wb_valid && (wb_addr == instr_rs1);
    assign wb_hit_rd  = wb_valid && (wb_addr == instr_rd);

    // A writeback landing this cycle resolves the hazard it would otherwise cause.
    assign hazard = (pending_q[instr_rs0] && !wb_hit_rs0)
                  || (!instr_use_imm && pending_q[instr_rs1] && !wb_hit_rs1)
                  || (instr_wr_en && pending_q[instr_rd] && !wb_hit_rd);

    assign instr_ready = !reset && !hazard && (!alu_valid_q || alu_ready);
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        op0 = '0;
        op1 = '0;
        if (instr_rs0 != '0) begin
            op0 = wb_hit_rs0 ? wb_data : regs_q[instr_rs0];
        end
        if (instr_rs1 != '0) begin
            op1 = wb_hit_rs1 ? wb_data : regs_q[instr_rs1];
        end
    end

    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        if (wb_write) begin
            regs_d[wb_addr]    = wb_data;
            pending_d[wb_addr] = 1'b0;
        end
        // Set after clear so a same-rd issue re-marks the register pending.
        if (accept && instr_wr_en && (instr_rd != '0)) begin
            pending_d[instr_rd] = 1'b1;
        end
    end

    always_comb begin
        alu_valid_d = alu_valid_q;
        alu_ctrl_d  = alu_ctrl_q;
        alu_in0_d   = alu_in0_q;
        alu_in1_d   = alu_in1_q;
        alu_rd_d    = alu_rd_q;
        alu_wr_en_d = alu_wr_en_q;
        if (accept) begin
            alu_valid_d = 1'b1;
            alu_ctrl_d  = instr_alu_op;
            alu_in0_d   = op0;
            alu_in1_d   = instr_use_imm ? instr_imm : op1;
            alu_rd_d    = instr_rd;
            alu_wr_en_d = instr_wr_en;
        end else if (alu_valid_q && alu_ready) begin
            alu_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q   <= '0;
            alu_valid_q <= 1'b0;
            alu_ctrl_q  <= '0;
            alu_in0_q   <= '0;
            alu_in1_q   <= '0;
            alu_rd_q    <= '0;
            alu_wr_en_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q   <= pending_d;
            alu_valid_q <= alu_valid_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_in0_q   <= alu_in0_d;
            alu_in1_q   <= alu_in1_d;
            alu_rd_q    <= alu_rd_d;
            alu_wr_en_q <= alu_wr_en_d;
        end
    end

    assign alu_valid = alu_valid_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign alu_in0   = alu_in0_q;
    assign alu_in1   = alu_in1_q;
    assign alu_rd    = alu_rd_q;
    assign alu_wr_en = alu_wr_en_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: bypass, RAW/WAW stalls, backpressure,
// immediates, r0 rules and mid-operation reset.
module tb_alu_operand_stage;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk;
    logic          reset;
    logic          instr_valid;
    logic          instr_ready;
    logic [7:0]    instr_alu_op;
    logic [AW-1:0] instr_rs0, instr_rs1, instr_rd;
    logic [DW-1:0] instr_imm;
    logic          instr_use_imm, instr_wr_en;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          alu_valid, alu_ready;
    logic [7:0]    alu_ctrl;
    logic [DW-1:0] alu_in0, alu_in1;
    logic [AW-1:0] alu_rd;
    logic          alu_wr_en;

    int vec_cnt = 0;
    int err_cnt = 0;

    alu_operand_stage #(.DATA_WIDTH(DW), .NUM_REGS(16), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_alu_op(instr_alu_op), .instr_rs0(instr_rs0), .instr_rs1(instr_rs1),
        .instr_imm(instr_imm), .instr_use_imm(instr_use_imm),
        .instr_rd(instr_rd), .instr_wr_en(instr_wr_en),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_ctrl(alu_ctrl),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_rd(alu_rd), .alu_wr_en(alu_wr_en)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_instr(input logic [7:0] op, input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                             input logic [DW-1:0] imm, input logic use_imm,
                             input logic [AW-1:0] rd, input logic wr_en);
        instr_valid   = 1'b1;
        instr_alu_op  = op;
        instr_rs0     = rs0;
        instr_rs1     = rs1;
        instr_imm     = imm;
        instr_use_imm = use_imm;
        instr_rd      = rd;
        instr_wr_en   = wr_en;
    endtask

    task automatic idle();
        instr_valid   = 1'b0;
        instr_alu_op  = '0;
        instr_rs0     = '0;
        instr_rs1     = '0;
        instr_imm     = '0;
        instr_use_imm = 1'b0;
        instr_rd      = '0;
        instr_wr_en   = 1'b0;
    endtask

    task automatic set_wb(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
    endtask

    // Scenario tasks
    task automatic test_reset();
        reset = 1'b1;
        alu_ready = 1'b1;
        set_wb(1'b0, '0, '0);
        set_instr(8'h01, 4'd1, 4'd2, '0, 1'b0, 4'd0, 1'b0);
        tick();
        tick();
        vec_cnt++; if (instr_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_ready: got %b exp 0", instr_ready); end
        idle();
        reset = 1'b0;
        settle();
        vec_cnt++; if (alu_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b exp 0", alu_valid); end
        vec_cnt++; if (alu_ctrl !== 8'h00) begin err_cnt++; $display("FAIL reset_ctrl: got %h exp 00", alu_ctrl); end
        vec_cnt++; if (alu_in0 !== 32'h0 || alu_in1 !== 32'h0) begin err_cnt++; $display("FAIL reset_ins: got %h/%h exp 0/0", alu_in0, alu_in1); end
        vec_cnt++; if (alu_rd !== 4'd0 || alu_wr_en !== 1'b0) begin err_cnt++; $display("FAIL reset_rd: got %h/%b exp 0/0", alu_rd, alu_wr_en); end
        vec_cnt++; if (instr_ready !== 1'b1) begin err_cnt++; $display("FAIL post_reset_ready: got %b exp 1", instr_ready); end
    endtask

    task automatic test_basic();
        set_instr(8'h01, 4'd1, 4'd2, '0, 1'b0, 4'd0, 1'b0);
        tick();
        vec_cnt++; if (alu_valid !== 1'b1) begin err_cnt++; $display("FAIL basic_valid: got %b exp 1", alu_valid); end
        vec_cnt++; if (alu_ctrl !== 8'h01) begin err_cnt++; $display("FAIL basic_ctrl: got %h exp 01", alu_ctrl); end
        vec_cnt++; if (alu_in0 !== 32'h0 || alu_in1 !== 32'h0) begin err_cnt++; $display("FAIL basic_ins: got %h/%h exp 0/0", alu_in0, alu_in1); end
        idle();
        tick();
        vec_cnt++; if (alu_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_drain: got %b exp 0", alu_valid); end
    endtask

    task automatic test_bypass();
        set_wb(1'b1, 4'd3, 32'h1234);
        set_instr(8'h02, 4'd3, 4'd0, '0, 1'b0, 4'd0, 1'b0);
        tick();
        set_wb(1'b0, '0, '0);
        vec_cnt++; if (alu_in0 !== 32'h1234) begin err_cnt++; $display("FAIL bypass_in0: got %h exp 1234", alu_in0); end
        set_instr(8'h03, 4'd0, 4'd3, '0, 1'b0, 4'd0, 1'b0);
        tick();
        vec_cnt++; if (alu_in1 !== 32'h1234 || alu_ctrl !== 8'h03) begin err_cnt++; $display("FAIL bypass_array: got %h/%h exp 1234/03", alu_in1, alu_ctrl); end
        idle();
        tick();
    endtask

    task automatic test_raw();
        set_instr(8'h04, 4'd0, 4'd0, '0, 1'b0, 4'd5, 1'b1);
        tick();
        set_instr(8'h05, 4'd5, 4'd0, '0, 1'b0, 4'd0, 1'b0);
        settle();
        for (int i = 0; i < 4; i++) begin
            vec_cnt++; if (instr_ready !== 1'b0) begin err_cnt++; $display("FAIL raw_stall%0d: got %b exp 0", i, instr_ready); end
            tick();
        end
        set_wb(1'b1, 4'd5, 32'hAB);
        settle();
        vec_cnt++; if (instr_ready !== 1'b1) begin err_cnt++; $display("FAIL raw_release: got %b exp 1", instr_ready); end
        tick();
        set_wb(1'b0, '0, '0);
        vec_cnt++; if (alu_valid !== 1'b1 || alu_ctrl !== 8'h05 || alu_in0 !== 32'hAB) begin err_cnt++; $display("FAIL raw_operand: got %b/%h/%h exp 1/05/ab", alu_valid, alu_ctrl, alu_in0); end
        set_instr(8'h06, 4'd5, 4'd0, '0, 1'b0, 4'd0, 1'b0);
        settle();
        vec_cnt++; if (instr_ready !== 1'b1) begin err_cnt++; $display("FAIL raw_cleared: got %b exp 1", instr_ready); end
        tick();
        vec_cnt++; if (alu_in0 !== 32'hAB) begin err_cnt++; $display("FAIL raw_written: got %h exp ab", alu_in0); end
        // WAW, then a writer that re-marks its own rd in the release cycle
        set_instr(8'h20, 4'd0, 4'd0, '0, 1'b0, 4'd6, 1'b1);
        tick();
        set_instr(8'h21, 4'd0, 4'd0, '0, 1'b0, 4'd6, 1'b1);
        settle();
        vec_cnt++; if (instr_ready !== 1'b0) begin err_cnt++; $display("FAIL waw_stall: got %b exp 0", instr_ready); end
        tick();
        set_wb(1'b1, 4'd6, 32'h66);
        settle();
        vec_cnt++; if (instr_ready !== 1'b1) begin err_cnt++; $display("FAIL waw_release: got %b exp 1", instr_ready); end
        tick();
        set_wb(1'b0, '0, '0);
        set_instr(8'h22, 4'd6, 4'd0, '0, 1'b0, 4'd0, 1'b0);
        settle();
        vec_cnt++; if (instr_ready !== 1'b0) begin err_cnt++; $display("FAIL set_wins: got %b exp 0", instr_ready); end
        tick();
        idle();
        set_wb(1'b1, 4'd6, 32'h67);
        tick();
        set_wb(1'b0, '0, '0);
    endtask

    task automatic test_backpressure();
        idle();
        alu_ready = 1'b1;
        tick();
        alu_ready = 1'b0;
        set_instr(8'h07, 4'd3, 4'd0, 32'h55, 1'b1, 4'd2, 1'b0);
        settle();
        vec_cnt++; if (instr_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_empty_ready: got %b exp 1", instr_ready); end
        tick();
        set_instr(8'h08, 4'd0, 4'd0, 32'h66, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            vec_cnt++; if (instr_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_ready%0d: got %b exp 0", i, instr_ready); end
            vec_cnt++; if (alu_valid !== 1'b1 || alu_ctrl !== 8'h07 || alu_in0 !== 32'h1234 || alu_in1 !== 32'h55 || alu_rd !== 4'd2)
                begin err_cnt++; $display("FAIL bp_hold%0d: got %b/%h/%h/%h/%h exp 1/07/1234/55/2", i, alu_valid, alu_ctrl, alu_in0, alu_in1, alu_rd); end
            tick();
        end
        alu_ready = 1'b1;
        settle();
        vec_cnt++; if (instr_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_resume_ready: got %b exp 1", instr_ready); end
        tick();
        vec_cnt++; if (alu_valid !== 1'b1 || alu_ctrl !== 8'h08 || alu_in1 !== 32'h66) begin err_cnt++; $display("FAIL bp_next: got %b/%h/%h exp 1/08/66", alu_valid, alu_ctrl, alu_in1); end
        idle();
        tick();
    endtask

    task automatic test_imm();
        set_instr(8'h30, 4'd0, 4'd0, '0, 1'b0, 4'd5, 1'b1);
        tick();
        set_instr(8'h31, 4'd0, 4'd5, 32'hFFFF_FFFF, 1'b1, 4'd0, 1'b0);
        settle();
        vec_cnt++; if (instr_ready !== 1'b1) begin err_cnt++; $display("FAIL imm_no_stall: got %b exp 1", instr_ready); end
        tick();
        vec_cnt++; if (alu_in1 !== 32'hFFFF_FFFF || alu_ctrl !== 8'h31) begin err_cnt++; $display("FAIL imm_in1: got %h/%h exp ffffffff/31", alu_in1, alu_ctrl); end
        set_instr(8'h32, 4'd0, 4'd0, 32'h1, 1'b1, 4'd5, 1'b1);
        settle();
        vec_cnt++; if (instr_ready !== 1'b0) begin err_cnt++; $display("FAIL imm_rd_stall: got %b exp 0", instr_ready); end
        tick();
        vec_cnt++; if (instr_ready !== 1'b0 || alu_valid !== 1'b0) begin err_cnt++; $display("FAIL imm_rd_stall2: got %b/%b exp 0/0", instr_ready, alu_valid); end
        idle();
        set_wb(1'b1, 4'd5, 32'h55);
        tick();
        set_wb(1'b0, '0, '0);
    endtask

    task automatic test_r0();
        set_wb(1'b1, 4'd0, 32'h5);
        tick();
        set_wb(1'b0, '0, '0);
        set_instr(8'h40, 4'd0, 4'd0, '0, 1'b0, 4'd0, 1'b0);
        tick();
        vec_cnt++; if (alu_in0 !== 32'h0 || alu_in1 !== 32'h0) begin err_cnt++; $display("FAIL r0_read: got %h/%h exp 0/0", alu_in0, alu_in1); end
        set_wb(1'b1, 4'd0, 32'h9);
        set_instr(8'h41, 4'd0, 4'd0, '0, 1'b0, 4'd0, 1'b0);
        tick();
        set_wb(1'b0, '0, '0);
        vec_cnt++; if (alu_in0 !== 32'h0 || alu_ctrl !== 8'h41) begin err_cnt++; $display("FAIL r0_bypass: got %h/%h exp 0/41", alu_in0, alu_ctrl); end
        set_instr(8'h42, 4'd0, 4'd0, '0, 1'b0, 4'd0, 1'b1);
        tick();
        vec_cnt++; if (alu_wr_en !== 1'b1 || alu_rd !== 4'd0) begin err_cnt++; $display("FAIL r0_carry: got %b/%h exp 1/0", alu_wr_en, alu_rd); end
        set_instr(8'h43, 4'd0, 4'd0, '0, 1'b0, 4'd0, 1'b1);
        settle();
        vec_cnt++; if (instr_ready !== 1'b1) begin err_cnt++; $display("FAIL r0_no_pending: got %b exp 1", instr_ready); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_mid_reset();
        set_wb(1'b1, 4'd7, 32'h700);
        tick();
        set_wb(1'b0, '0, '0);
        set_instr(8'h50, 4'd0, 4'd0, '0, 1'b0, 4'd7, 1'b1);
        tick();
        vec_cnt++; if (alu_valid !== 1'b1) begin err_cnt++; $display("FAIL mr_loaded: got %b exp 1", alu_valid); end
        idle();
        alu_ready = 1'b0;
        reset = 1'b1;
        settle();
        vec_cnt++; if (instr_ready !== 1'b0) begin err_cnt++; $display("FAIL mr_ready: got %b exp 0", instr_ready); end
        tick();
        vec_cnt++; if (alu_valid !== 1'b0 || alu_ctrl !== 8'h00 || alu_wr_en !== 1'b0) begin err_cnt++; $display("FAIL mr_cleared: got %b/%h/%b exp 0/00/0", alu_valid, alu_ctrl, alu_wr_en); end
        reset = 1'b0;
        alu_ready = 1'b1;
        set_instr(8'h51, 4'd7, 4'd0, '0, 1'b0, 4'd7, 1'b1);
        settle();
        vec_cnt++; if (instr_ready !== 1'b1) begin err_cnt++; $display("FAIL mr_no_stall: got %b exp 1", instr_ready); end
        tick();
        vec_cnt++; if (alu_in0 !== 32'h0) begin err_cnt++; $display("FAIL mr_reg_cleared: got %h exp 0", alu_in0); end
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        set_wb(1'b1, 4'd1, 32'h11);
        tick();
        set_wb(1'b1, 4'd2, 32'h22);
        tick();
        set_wb(1'b0, '0, '0);
        set_instr(8'h10, 4'd1, 4'd2, '0, 1'b0, 4'd0, 1'b0);
        settle();
        vec_cnt++; if (instr_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready0: got %b exp 1", instr_ready); end
        tick();
        vec_cnt++; if (alu_ctrl !== 8'h10 || alu_in0 !== 32'h11 || alu_in1 !== 32'h22) begin err_cnt++; $display("FAIL b2b_0: got %h/%h/%h exp 10/11/22", alu_ctrl, alu_in0, alu_in1); end
        set_instr(8'h11, 4'd2, 4'd0, 32'h3, 1'b1, 4'd0, 1'b0);
        settle();
        vec_cnt++; if (instr_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready1: got %b exp 1", instr_ready); end
        tick();
        vec_cnt++; if (alu_ctrl !== 8'h11 || alu_in0 !== 32'h22 || alu_in1 !== 32'h3) begin err_cnt++; $display("FAIL b2b_1: got %h/%h/%h exp 11/22/3", alu_ctrl, alu_in0, alu_in1); end
        set_instr(8'h12, 4'd1, 4'd1, '0, 1'b0, 4'd0, 1'b0);
        tick();
        vec_cnt++; if (alu_valid !== 1'b1 || alu_ctrl !== 8'h12 || alu_in1 !== 32'h11) begin err_cnt++; $display("FAIL b2b_2: got %b/%h/%h exp 1/12/11", alu_valid, alu_ctrl, alu_in1); end
        idle();
        tick();
    endtask

    initial begin
        idle();
        set_wb(1'b0, '0, '0);
        alu_ready = 1'b1;
        reset = 1'b1;
        test_reset();
        test_basic();
        test_bypass();
        test_raw();
        test_backpressure();
        test_imm();
        test_r0();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch stage directly upstream of the ALU.
- Holds the architectural register file and a pending-write scoreboard.
- Accepts decoded instructions, reads operands with same-cycle writeback bypass, stalls on read-after-write and write-after-write hazards, and presents ctrl/in0/in1 to the ALU through a valid/ready output register.
- Accepts ALU results back through the writeback port.

Parameters:
- DATA_WIDTH, 32, operand/register width.
- NUM_REGS, 16, number of registers (power of two, >= 2).
- REG_ADDR_WIDTH, 4, log2(NUM_REGS).

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  decoded instruction present.
- instr_ready  output  1  stage accepts instruction this cycle.
- instr_alu_op  input  8  ALU ctrl code, passed through.
- instr_rs0  input  REG_ADDR_WIDTH  source register for in0.
- instr_rs1  input  REG_ADDR_WIDTH  source register for in1.
- instr_imm  input  DATA_WIDTH  immediate operand.
- instr_use_imm  input  1  1: in1 = instr_imm, rs1 unused.
- instr_rd  input  REG_ADDR_WIDTH  destination register.
- instr_wr_en  input  1  instruction writes rd.
- wb_valid  input  1  writeback strobe.
- wb_addr  input  REG_ADDR_WIDTH  writeback register.
- wb_data  input  DATA_WIDTH  writeback value.
- alu_valid  output  1  output register holds an instruction.
- alu_ready  input  1  downstream consumes.
- alu_ctrl  output  8  to ALU ctrl.
- alu_in0  output  DATA_WIDTH  to ALU in0.
- alu_in1  output  DATA_WIDTH  to ALU in1.
- alu_rd  output  REG_ADDR_WIDTH  destination, carried with result.
- alu_wr_en  output  1  destination write enable, carried with result.

Behaviour:
- Reset, synchronous, active-high:
  - All registers cleared to 0 and all pending bits cleared.
  - alu_valid, alu_ctrl, alu_in0, alu_in1, alu_rd and alu_wr_en all 0.
  - instr_ready forced 0 while reset is high.
  - Reset mid-operation discards any held instruction and all pending writes.
- Register 0:
  - Reads always return 0.
  - Writebacks to address 0 are ignored.
  - An instruction with rd=0 never sets a pending bit.
- Writeback:
  - When wb_valid and wb_addr!=0, reg[wb_addr] <= wb_data and pending[wb_addr] <= 0 on the next edge.
  - A writeback to a non-pending register still writes.
- Bypass:
  - If wb_valid and wb_addr equals a source address (nonzero) in the accept cycle, the operand is taken from wb_data, not the register array.
- Hazard (combinational):
  - hazard = (pending[rs0] & !(wb_valid & wb_addr==rs0))
  - | (!instr_use_imm & pending[rs1] & !(wb_valid & wb_addr==rs1))
  - | (instr_wr_en & pending[rd] & !(wb_valid & wb_addr==rd))
  - Pending bits at address 0 are always 0.
- Handshake:
  - instr_ready = !reset & !hazard & (!alu_valid | alu_ready).
  - Accept = instr_valid & instr_ready. On accept:
    - Output register loads alu_ctrl=instr_alu_op, alu_in0=op(rs0), alu_in1 = instr_use_imm ? instr_imm : op(rs1), alu_rd=instr_rd, alu_wr_en=instr_wr_en.
    - alu_valid <= 1.
    - If instr_wr_en & rd!=0, pending[rd] <= 1.
  - Simultaneous clear and set on the same rd: set wins.
  - If alu_valid & alu_ready and there is no accept, alu_valid <= 0.
  - If alu_valid & !alu_ready, all alu_* outputs hold stable.
- Latency:
  - 1 cycle from accept to alu_valid.
  - Full throughput when there are no hazards and alu_ready=1.
- instr_ready does not depend on instr_valid.

Test Plan:
- Reset, then accept rs0=1, rs1=2, op=8'd1 -> next cycle alu_valid=1, alu_ctrl=1, alu_in0=0, alu_in1=0.
- wb_valid addr=3 data=0x1234 in the same cycle as accepting rs0=3 -> alu_in0=0x1234 (bypass); later read of r3 also gives 0x1234.
- RAW stall:
  - Accept A (rd=5, wr_en=1); present B (rs0=5) -> instr_ready=0 for 4 cycles.
  - Assert wb_valid addr=5 data=0xAB -> B accepted that cycle, alu_in0=0xAB, pending[5] re-set only if B writes r5.
- Backpressure:
  - alu_ready=0 with alu_valid=1 -> instr_ready=0 and alu_* stable for 3 cycles.
  - alu_ready=1 -> the held instruction is consumed and a new one is accepted the same cycle.
- Immediate:
  - use_imm=1, imm=0xFFFFFFFF, rs1=5 pending -> accepted (no stall on rs1), alu_in1=0xFFFFFFFF.
  - A stall on rd pending is still enforced.
- r0 and mid-operation reset:
  - wb addr=0 data=5, then read r0 -> 0; instruction with rd=0 wr_en=1 leaves no pending bit.
  - Reset asserted with alu_valid=1 and pending[7]=1 -> next cycle alu_valid=0, pending clear, a read of r7 does not stall.
